sevenseg_scan: RTL and testbench

//   Multiplexed seven-segment display driver, downstream of the SoC's 56-bit

---
 rtl/sevenseg_scan.sv | 106 ++++++++++
 tb/tb_sevenseg_scan.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan.sv
// Multiplexed seven-segment driver: scans NUM_DIGITS digits onto shared segment
// lines with a blanking guard per slot and a once-per-frame pattern latch.
module sevenseg_scan #(
  parameter int NUM_DIGITS     = 8,
  parameter int REFRESH_DIV    = 100000,
  parameter int BLANK_CYCLES   = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [7*NUM_DIGITS-1:0] sevenseg,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0]         CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0]         CNT_BLANK = CW'(BLANK_CYCLES);
  localparam logic [DW-1:0]         DIG_LAST  = DW'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_OFF   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF    = AN_ACTIVE_LOW ? '1 : '0;

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  logic                    r_run;
  logic [CW-1:0]           r_cnt;
  logic [DW-1:0]           r_digit;
  logic [7*NUM_DIGITS-1:0] r_latch;
  logic [6:0]              r_seg;
  logic [NUM_DIGITS-1:0]   r_an;
  logic                    r_frame_start;

  logic [CW-1:0]           w_cnt_nxt;
  logic [DW-1:0]           w_digit_nxt;
  logic                    w_frame_nxt;
  logic [7*NUM_DIGITS-1:0] w_latch_nxt;
  logic [6:0]              w_pat;
  logic [NUM_DIGITS-1:0]   w_an_sel;
  state_t                  w_state_nxt;

  // Outputs are registered from the position being entered, so they always
  // describe the cycle in which they are visible. A stopped scan restarts at 0.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_cnt_nxt   = '0;
    w_digit_nxt = '0;
    w_pat       = '0;
    w_an_sel    = '0;
    if (r_run) begin
      if (r_cnt == CNT_LAST) begin
        w_digit_nxt = (r_digit == DIG_LAST) ? '0 : r_digit + 1'b1;
      end else begin
        w_cnt_nxt   = r_cnt + 1'b1;
        w_digit_nxt = r_digit;
      end
    end
    w_frame_nxt = (w_cnt_nxt == '0) && (w_digit_nxt == '0);
    w_latch_nxt = w_frame_nxt ? sevenseg : r_latch;
    w_state_nxt = (w_cnt_nxt < CNT_BLANK) ? ST_BLANK : ST_SHOW;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (w_digit_nxt == DW'(d)) begin
        w_pat       = w_latch_nxt[7*d +: 7];
        w_an_sel[d] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; disable shares the path so both abort the frame alike.
    if (!reset_n || !enable) begin
      r_run         <= 1'b0;
      r_cnt         <= '0;
      r_digit       <= '0;
      r_latch       <= '0;
      r_an          <= AN_OFF;
      r_seg         <= SEG_OFF;
      r_frame_start <= 1'b0;
    end else begin
      r_run         <= 1'b1;
      r_cnt         <= w_cnt_nxt;
      r_digit       <= w_digit_nxt;
      r_latch       <= w_latch_nxt;
      r_frame_start <= w_frame_nxt;
      case (w_state_nxt)
        ST_SHOW: begin
          r_an  <= w_an_sel ^ AN_OFF;
          r_seg <= w_pat ^ SEG_OFF;
        end
        default: begin
          r_an  <= AN_OFF;
          r_seg <= SEG_OFF;
        end
      endcase
    end
  end

  assign seg         = r_seg;
  assign an          = r_an;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Directed and invariant checks for sevenseg_scan with REFRESH_DIV=8 and
// BLANK_CYCLES=2, on a 4-digit and a 3-digit instance.
module tb_sevenseg_scan;

  localparam logic [27:0] PAT_P = {7'h4F, 7'h5B, 7'h06, 7'h3F};
  localparam logic [27:0] PAT_Q = {7'h7F, 7'h6D, 7'h66, 7'h07};

  logic        clk = 1'b0;
  logic        reset_n4 = 1'b0, enable4 = 1'b1;
  logic [27:0] sevenseg4 = '0;
  logic [6:0]  seg4;
  logic [3:0]  an4;
  logic        fs4;
  logic        reset_n3 = 1'b0, enable3 = 1'b1;
  logic [20:0] sevenseg3 = '0;
  logic [6:0]  seg3;
  logic [2:0]  an3;
  logic        fs3;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sevenseg_scan #(.NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2),
                  .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut4 (
    .clk(clk), .reset_n(reset_n4), .enable(enable4), .sevenseg(sevenseg4),
    .seg(seg4), .an(an4), .frame_start(fs4));

  sevenseg_scan #(.NUM_DIGITS(3), .REFRESH_DIV(8), .BLANK_CYCLES(2),
                  .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut3 (
    .clk(clk), .reset_n(reset_n3), .enable(enable3), .sevenseg(sevenseg3),
    .seg(seg3), .an(an3), .frame_start(fs3));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // NOTE: outputs are sampled 1 time unit after the rising edge, never on it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs in cycle k of a scan: 8-cycle slots, first 2 blank.
  task automatic expect_cycle(input string tag, input int k, input int nd,
                              input logic [55:0] pat, input logic [31:0] an_obs,
                              input logic [6:0] seg_obs, input logic fs_obs);
    int          slot, dig;
    logic [31:0] an_mask, an_exp;
    logic [6:0]  seg_exp;
    slot    = k % 8;
    dig     = (k / 8) % nd;
    an_mask = (32'd1 << nd) - 32'd1;
    if (slot < 2) begin
      an_exp  = an_mask;
      seg_exp = 7'h7F;
    end else begin
      an_exp  = an_mask & ~(32'd1 << dig);
      seg_exp = ~pat[7*dig +: 7];
    end
    check($sformatf("%s an k=%0d", tag, k), an_obs, an_exp);
    check($sformatf("%s seg k=%0d", tag, k), 32'(seg_obs), 32'(seg_exp));
    check($sformatf("%s fs k=%0d", tag, k), 32'(fs_obs), 32'((k % (8*nd)) == 0));
  endtask

  task automatic reset4();
    reset_n4 = 1'b0;
    enable4  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst4 an", 32'(an4), 32'hF);
      check("rst4 seg", 32'(seg4), 32'h7F);
      check("rst4 fs", 32'(fs4), 32'h0);
    end
    reset_n4 = 1'b1;
    step();
  endtask

  initial begin
    // Test 1: reset and basic scan, digit 0 shows segment a only.
    sevenseg4 = 28'h0000001;
    reset4();
    for (int k = 0; k < 34; k++) begin
      expect_cycle("t1", k, 4, 56'(sevenseg4), 32'(an4), seg4, fs4);
      step();
    end

    // Test 2: mid-frame change is held off until the next frame.
    sevenseg4 = '0;
    reset4();
    for (int k = 0; k < 42; k++) begin
      expect_cycle("t2", k, 4, (k < 32) ? 56'h0 : 56'hFFFFFFF, 32'(an4), seg4, fs4);
      if (k == 12) sevenseg4 = '1;
      step();
    end

    // Test 3: enable gating, then a fresh frame with a new pattern.
    sevenseg4 = PAT_P;
    reset4();
    for (int k = 0; k < 20; k++) begin
      expect_cycle("t3a", k, 4, 56'(PAT_P), 32'(an4), seg4, fs4);
      if (k == 19) enable4 = 1'b0;
      step();
    end
    for (int j = 0; j < 5; j++) begin
      check("t3 off an", 32'(an4), 32'hF);
      check("t3 off seg", 32'(seg4), 32'h7F);
      check("t3 off fs", 32'(fs4), 32'h0);
      if (j == 4) begin
        enable4   = 1'b1;
        sevenseg4 = PAT_Q;
      end
      step();
    end
    for (int k = 0; k < 34; k++) begin
      expect_cycle("t3b", k, 4, 56'(PAT_Q), 32'(an4), seg4, fs4);
      step();
    end

    // Test 4: one-cycle reset in the middle of digit 1's slot.
    sevenseg4 = PAT_P;
    reset4();
    for (int k = 0; k < 13; k++) begin
      expect_cycle("t4a", k, 4, 56'(PAT_P), 32'(an4), seg4, fs4);
      if (k == 12) reset_n4 = 1'b0;
      step();
    end
    check("t4 rst an", 32'(an4), 32'hF);
    check("t4 rst seg", 32'(seg4), 32'h7F);
    check("t4 rst fs", 32'(fs4), 32'h0);
    reset_n4 = 1'b1;
    step();
    for (int k = 0; k < 12; k++) begin
      expect_cycle("t4b", k, 4, 56'(PAT_P), 32'(an4), seg4, fs4);
      step();
    end

    // Test 5: invariants under random pattern and enable.
    reset4();
    for (int i = 0; i < 1000; i++) begin
      enable4 = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 7) == 0) sevenseg4 = 28'($urandom);
      step();
      check("inv onehot", 32'($countones(~an4) <= 1), 32'h1);
      check("inv dark", 32'((an4 != 4'hF) || (seg4 == 7'h7F)), 32'h1);
    end

    // Three-digit instance: digit wrap 2 -> 0.
    sevenseg3 = 21'h000001;
    reset_n3  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst3 an", 32'(an3), 32'h7);
      check("rst3 seg", 32'(seg3), 32'h7F);
    end
    reset_n3 = 1'b1;
    step();
    for (int k = 0; k < 28; k++) begin
      expect_cycle("nd3", k, 3, 56'(sevenseg3), 32'(an3), seg3, fs3);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
